// File: rtl/aforo_ctrl_pkg.sv
// ============================================================================
//  Module      : aforo_ctrl_pkg
//  Description : Shared definitions for the occupancy controller: source index
//                encoding (entry = 2i, exit = 2i+1) and default limits.
//  Revision    : 1.0
// ============================================================================
`default_nettype none

package aforo_ctrl_pkg;

    localparam int unsigned CAPACIDAD_DEF = 100;
    localparam int unsigned HIST_DEF      = 5;

    typedef enum logic [1:0] {
        EV_NINGUNO = 2'd0,
        EV_ENTRADA = 2'd1,
        EV_SALIDA  = 2'd2
    } evento_t;

    function automatic int unsigned src_entrada(input int unsigned puerta);
        return 2 * puerta;
    endfunction

    function automatic int unsigned src_salida(input int unsigned puerta);
        return 2 * puerta + 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/aforo_rr_arb.sv
// ============================================================================
//  Module      : aforo_rr_arb
//  Description : Combinational round-robin arbiter; searches upward from ptr
//                with wrap and grants the first pending request.
//  Revision    : 1.0
// ============================================================================
`default_nettype none

module aforo_rr_arb #(
    parameter  int N  = 4,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] gnt_idx,
    output logic          gnt_valid
);

    always_comb begin
        logic [IW-1:0] w_s;
        w_s       = '0;
        gnt       = '0;
        gnt_idx   = '0;
        gnt_valid = 1'b0;
        for (int k = 0; k < N; k++) begin
            w_s = IW'((int'(ptr) + k) % N);
            if (!gnt_valid && req[w_s]) begin
                gnt_valid  = 1'b1;
                gnt[w_s]   = 1'b1;
                gnt_idx    = w_s;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/aforo_ctrl.sv
// ============================================================================
//  Module      : aforo_ctrl
//  Description : Buffers per-door entry/exit pulses, serves them round-robin
//                into a saturating occupancy counter with full/empty/alarm
//                status. AFORO_HIST_EN adds hysteresis to clearing lleno.
//  Revision    : 1.0
// ============================================================================
`default_nettype none

module aforo_ctrl
    import aforo_ctrl_pkg::*;
#(
    parameter int NUM_PUERTAS = 2,
    parameter int CNT_W       = 8,
    parameter int CAPACIDAD   = CAPACIDAD_DEF,
    parameter int HIST        = HIST_DEF
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_PUERTAS-1:0] sumar,
    input  logic [NUM_PUERTAS-1:0] restar,
    output logic [CNT_W-1:0]       cuenta,
    output logic                   lleno,
    output logic                   vacio,
    output logic                   alarma,
    output logic                   perdido,
    output logic                   error_neg
);

    localparam int NS = 2 * NUM_PUERTAS;
    localparam int PW = $clog2(NS);

    // Exact lleno behaves as a hysteresis of one count.
`ifdef AFORO_HIST_EN
    localparam int C_HIST_EFF = HIST;
`else
    localparam int C_HIST_EFF = 1 + 0 * HIST;
`endif
    localparam int               C_CLR_INT = (CAPACIDAD > C_HIST_EFF) ? (CAPACIDAD - C_HIST_EFF) : 0;
    localparam logic [CNT_W-1:0] C_CAP     = CNT_W'(CAPACIDAD);
    localparam logic [CNT_W-1:0] C_CLR     = CNT_W'(C_CLR_INT);

    logic [NS-1:0]    w_src;
    logic [NS-1:0]    r_pend;
    logic [PW-1:0]    r_ptr;
    logic [NS-1:0]    w_gnt;
    logic [PW-1:0]    w_gnt_idx;
    logic             w_gnt_valid;
    evento_t          w_evento;
    logic [CNT_W-1:0] w_cuenta_next;
    logic             w_alarma_next;
    logic             w_errneg_set;
    logic             w_perdido_set;
    logic             w_lleno_next;
    logic [PW-1:0]    w_ptr_next;

    logic [CNT_W-1:0] r_cuenta;
    logic             r_lleno;
    logic             r_vacio;
    logic             r_alarma;
    logic             r_perdido;
    logic             r_error_neg;

    for (genvar i = 0; i < NUM_PUERTAS; i++) begin : g_src
        assign w_src[src_entrada(i)] = sumar[i];
        assign w_src[src_salida(i)]  = restar[i];
    end

    aforo_rr_arb #(
        .N (NS)
    ) u_arb (
        .req       (r_pend),
        .ptr       (r_ptr),
        .gnt       (w_gnt),
        .gnt_idx   (w_gnt_idx),
        .gnt_valid (w_gnt_valid)
    );

    // Odd source indices are exits.
    always_comb begin
        w_evento = EV_NINGUNO;
        if (w_gnt_valid) begin
            w_evento = w_gnt_idx[0] ? EV_SALIDA : EV_ENTRADA;
        end
    end

    always_comb begin
        w_cuenta_next = r_cuenta;
        w_alarma_next = 1'b0;
        w_errneg_set  = 1'b0;
        case (w_evento)
            EV_ENTRADA: begin
                if (r_cuenta < C_CAP) w_cuenta_next = r_cuenta + 1'b1;
                else                  w_alarma_next = 1'b1;
            end
            EV_SALIDA: begin
                if (r_cuenta != '0) w_cuenta_next = r_cuenta - 1'b1;
                else                w_errneg_set  = 1'b1;
            end
            default: ;
        endcase
    end

    always_comb begin
        w_lleno_next = r_lleno;
        if (w_cuenta_next == C_CAP)       w_lleno_next = 1'b1;
        else if (w_cuenta_next <= C_CLR)  w_lleno_next = 1'b0;
    end

    always_comb begin
        w_ptr_next = r_ptr;
        if (w_gnt_valid) begin
            w_ptr_next = (w_gnt_idx == PW'(NS - 1)) ? '0 : w_gnt_idx + 1'b1;
        end
    end

    // A pulse landing on a bit that stays pending is the only way to lose one.
    assign w_perdido_set = |(w_src & r_pend & ~w_gnt);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pend      <= '0;
            r_ptr       <= '0;
            r_cuenta    <= '0;
            r_lleno     <= 1'b0;
            r_vacio     <= 1'b1;
            r_alarma    <= 1'b0;
            r_perdido   <= 1'b0;
            r_error_neg <= 1'b0;
        end else begin
            r_pend      <= (r_pend & ~w_gnt) | w_src;
            r_ptr       <= w_ptr_next;
            r_cuenta    <= w_cuenta_next;
            r_lleno     <= w_lleno_next;
            r_vacio     <= (w_cuenta_next == '0);
            r_alarma    <= w_alarma_next;
            r_perdido   <= r_perdido | w_perdido_set;
            r_error_neg <= r_error_neg | w_errneg_set;
        end
    end

    assign cuenta    = r_cuenta;
    assign lleno     = r_lleno;
    assign vacio     = r_vacio;
    assign alarma    = r_alarma;
    assign perdido   = r_perdido;
    assign error_neg = r_error_neg;

endmodule

`default_nettype wire
